// File: rtl/canny_nms_classify.sv
// canny_nms_classify
//   Non-maximum suppression plus hysteresis pre-classification for the Canny
//   chain. Takes per-pixel gradient magnitude and quantised direction from the
//   Sobel stage, builds a 3x3 window from two internal line buffers, suppresses
//   non-maximal centres along the gradient direction and classifies the
//   survivors as weak (01) or strong (10). Sync signals are delayed by the
//   same three clocks as the data path.
//
// Ports
//   clk              pixel clock
//   rst_s            asynchronous active-high reset
//   pre_frame_vsync  input frame sync
//   pre_frame_href   input line valid
//   pre_frame_clken  input pixel strobe
//   grad_mag [7:0]   gradient magnitude
//   grad_dir [1:0]   sector: 0 = L/R, 1 = UR/DL, 2 = U/D, 3 = UL/DR
//   post_frame_vsync pre_frame_vsync delayed 3 clk
//   post_frame_href  pre_frame_href delayed 3 clk
//   post_frame_clken pre_frame_clken delayed 3 clk
//   max_g [1:0]      00 suppressed/below low, 01 weak, 10 strong
module canny_nms_classify #(
    parameter int         IMG_WIDTH = 640,
    parameter logic [7:0] HIGH_TH   = 8'd60,
    parameter logic [7:0] LOW_TH    = 8'd30
) (
    input  logic       clk,
    input  logic       rst_s,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_href,
    input  logic       pre_frame_clken,
    input  logic [7:0] grad_mag,
    input  logic [1:0] grad_dir,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [1:0] max_g
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    // Two spare bits so the column counter can run past the line width and
    // saturate without wrapping back into the valid range.
    localparam int XW = AW + 2;
    localparam int YW = 12;

    logic          vsync_q, href_q;
    logic          vs_rise, href_rise, href_fall;
    logic [XW-1:0] x_cnt, x_cur;
    logic [YW-1:0] y_cnt, y_cur;
    logic          x_in_range;
    logic [AW-1:0] lb_addr;

    logic [9:0]    lb1 [IMG_WIDTH];
    logic [7:0]    lb2 [IMG_WIDTH];

    logic [7:0]    s1_top, s1_bot;
    logic [9:0]    s1_mid;
    logic          s1_ok;

    logic [7:0]    w_top [3];
    logic [7:0]    w_mid [3];
    logic [7:0]    w_bot [3];
    logic [1:0]    dir_mid1, dir_mid2;
    logic          s2_ok;

    logic [2:0]    vs_d, hr_d, ck_d;
    logic [7:0]    nb_a, nb_b, c_mag;
    logic          keep;
    logic [1:0]    cls;

    // Edge detection on the syncs. The counters are used combinationally for
    // the current pixel, so a pixel arriving on the first href cycle already
    // sees column 0 (and likewise row 0 on the vsync edge).
    assign vs_rise   = pre_frame_vsync & ~vsync_q;
    assign href_rise = pre_frame_href & ~href_q;
    assign href_fall = ~pre_frame_href & href_q;

    always_comb begin
        x_cur      = href_rise ? '0 : x_cnt;
        y_cur      = vs_rise ? '0 : y_cnt;
        x_in_range = (x_cur < XW'(IMG_WIDTH));
        lb_addr    = x_cur[AW-1:0];
    end

    // Column/row counters, both saturating.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            vsync_q <= pre_frame_vsync;
            href_q  <= pre_frame_href;
            if (pre_frame_clken)
                x_cnt <= (x_cur == '1) ? x_cur : x_cur + 1'b1;
            else if (href_rise)
                x_cnt <= '0;
            if (vs_rise)
                y_cnt <= '0;
            else if (href_fall && y_cnt != '1)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    // Line-buffer RAMs: no reset, stale contents are masked by the row check.
    // Nonblocking writes give old-data read-during-write behaviour.
    always_ff @(posedge clk) begin
        if (pre_frame_clken && x_in_range) begin
            lb1[lb_addr] <= {grad_dir, grad_mag};
            lb2[lb_addr] <= lb1[lb_addr][7:0];
        end
    end

    // Stage 1: line-buffer read plus the current pixel, one column of the
    // window per accepted pixel. s1_ok marks a complete, in-range window.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            s1_top <= '0;
            s1_mid <= '0;
            s1_bot <= '0;
            s1_ok  <= 1'b0;
        end else if (pre_frame_clken) begin
            s1_top <= lb2[lb_addr];
            s1_mid <= lb1[lb_addr];
            s1_bot <= grad_mag;
            s1_ok  <= x_in_range && (x_cur >= XW'(2)) && (y_cur >= YW'(2));
        end
    end

    // Stage 2: 3x3 window, shifting only for pixels that actually arrived so
    // clken gaps freeze it. Index 0 is column x-2, index 2 is column x.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            for (int i = 0; i < 3; i++) begin
                w_top[i] <= '0;
                w_mid[i] <= '0;
                w_bot[i] <= '0;
            end
            dir_mid1 <= '0;
            dir_mid2 <= '0;
            s2_ok    <= 1'b0;
        end else if (ck_d[0]) begin
            for (int i = 0; i < 2; i++) begin
                w_top[i] <= w_top[i+1];
                w_mid[i] <= w_mid[i+1];
                w_bot[i] <= w_bot[i+1];
            end
            w_top[2] <= s1_top;
            w_mid[2] <= s1_mid[7:0];
            w_bot[2] <= s1_bot;
            dir_mid2 <= s1_mid[9:8];
            dir_mid1 <= dir_mid2;
            s2_ok    <= s1_ok;
        end
    end

    // Neighbour selection along the centre's gradient sector, then the
    // tie-keeping maximum test and the two thresholds.
    always_comb begin
        c_mag = w_mid[1];
        nb_a  = w_mid[0];
        nb_b  = w_mid[2];
        case (dir_mid1)
            2'd1: begin nb_a = w_top[2]; nb_b = w_bot[0]; end
            2'd2: begin nb_a = w_top[1]; nb_b = w_bot[1]; end
            2'd3: begin nb_a = w_top[0]; nb_b = w_bot[2]; end
            default: begin nb_a = w_mid[0]; nb_b = w_mid[2]; end
        endcase
        keep = (c_mag >= nb_a) && (c_mag >= nb_b);
        if (c_mag >= HIGH_TH)
            cls = 2'b10;
        else if (c_mag >= LOW_TH)
            cls = 2'b01;
        else
            cls = 2'b00;
    end

    // Stage 3: classification register, forced to 00 whenever the output
    // strobe will be low.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s)
            max_g <= 2'b00;
        else if (ck_d[1] && s2_ok && keep)
            max_g <= cls;
        else
            max_g <= 2'b00;
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            vs_d <= '0;
            hr_d <= '0;
            ck_d <= '0;
        end else begin
            vs_d <= {vs_d[1:0], pre_frame_vsync};
            hr_d <= {hr_d[1:0], pre_frame_href};
            ck_d <= {ck_d[1:0], pre_frame_clken};
        end
    end

    assign post_frame_vsync = vs_d[2];
    assign post_frame_href  = hr_d[2];
    assign post_frame_clken = ck_d[2];

endmodule

// File: tb/tb_canny_nms_classify.sv
// tb_canny_nms_classify
//   Scoreboard bench for canny_nms_classify. Frames are described as small
//   images; every issued pixel pushes its expected class (computed directly
//   from image coordinates) into a queue that the monitor pops on each
//   output strobe. Sync delays are checked against a 3-deep history of the
//   driven syncs.
module tb_canny_nms_classify;

    localparam int IMG_W = 8;

    logic       clk = 1'b0;
    logic       rst_s = 1'b1;
    logic       pre_frame_vsync = 1'b0;
    logic       pre_frame_href = 1'b0;
    logic       pre_frame_clken = 1'b0;
    logic [7:0] grad_mag = '0;
    logic [1:0] grad_dir = '0;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [1:0] max_g;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sb[$];
    logic [2:0] h1 = '0, h2 = '0, h3 = '0;

    int         img_mag [0:7][0:15];
    logic [1:0] img_dir [0:7][0:15];

    canny_nms_classify #(
        .IMG_WIDTH(IMG_W),
        .HIGH_TH  (8'd60),
        .LOW_TH   (8'd30)
    ) dut (
        .clk             (clk),
        .rst_s           (rst_s),
        .pre_frame_vsync (pre_frame_vsync),
        .pre_frame_href  (pre_frame_href),
        .pre_frame_clken (pre_frame_clken),
        .grad_mag        (grad_mag),
        .grad_dir        (grad_dir),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .max_g           (max_g)
    );

    always #5 clk = ~clk;

    // History of the syncs as the DUT samples them, cleared with the DUT.
    always @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            h1 <= '0;
            h2 <= '0;
            h3 <= '0;
        end else begin
            h1 <= {pre_frame_vsync, pre_frame_href, pre_frame_clken};
            h2 <= h1;
            h3 <= h2;
        end
    end

    task automatic check_output(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: syncs every cycle, class popped on strobes, 00 elsewhere.
    always @(negedge clk) begin
        check_output("post_syncs", int'({post_frame_vsync, post_frame_href, post_frame_clken}),
                     int'(h3));
        if (!rst_s && post_frame_clken) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got max_g %0d expected no output", max_g);
            end else begin
                check_output("max_g", int'(max_g), int'(sb.pop_front()));
            end
        end else begin
            check_output("max_g_idle", int'(max_g), 0);
        end
    end

    // Reference: class of the input pixel (x,y) from its image neighbourhood.
    function automatic logic [1:0] model(input int x, input int y);
        int cx, cy, c, a, b;
        if (x < 2 || y < 2 || x >= IMG_W) return 2'b00;
        cx = x - 1;
        cy = y - 1;
        c  = img_mag[cy][cx];
        case (img_dir[cy][cx])
            2'd0: begin a = img_mag[cy][cx-1];   b = img_mag[cy][cx+1];   end
            2'd1: begin a = img_mag[cy-1][cx+1]; b = img_mag[cy+1][cx-1]; end
            2'd2: begin a = img_mag[cy-1][cx];   b = img_mag[cy+1][cx];   end
            default: begin a = img_mag[cy-1][cx-1]; b = img_mag[cy+1][cx+1]; end
        endcase
        if (c < a || c < b) return 2'b00;
        if (c >= 60) return 2'b10;
        if (c >= 30) return 2'b01;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode, input logic [1:0] d);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++) begin
                case (mode)
                    0: img_mag[y][x] = 50;
                    1: img_mag[y][x] = (x == 4) ? 100 : 20;
                    2: img_mag[y][x] = 10;
                    default: img_mag[y][x] = $urandom_range(0, 120);
                endcase
                img_dir[y][x] = (mode == 3) ? 2'($urandom_range(0, 3)) : d;
            end
        if (mode == 2) begin
            img_mag[2][2] = 70;
            img_mag[1][3] = 80;
        end
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        pre_frame_vsync = 1'b0;
        pre_frame_href  = 1'b0;
        pre_frame_clken = 1'b0;
        #1;
        check_output("reset_syncs", int'({post_frame_vsync, post_frame_href, post_frame_clken}), 0);
        check_output("reset_max_g", int'(max_g), 0);
        repeat (4) tick();
        sb.delete();
        rst_s = 1'b0;
        repeat (3) tick();
    endtask

    task automatic apply_stimulus(input int w, input int h, input int gap_pct, input int abort_row);
        pre_frame_vsync = 1'b1;
        repeat (2) tick();
        pre_frame_vsync = 1'b0;
        repeat (2) tick();
        for (int y = 0; y < h; y++) begin
            pre_frame_href = 1'b1;
            for (int x = 0; x < w; x++) begin
                if (y == abort_row && x == 4) begin
                    do_reset();
                    return;
                end
                while ($urandom_range(0, 99) < gap_pct) begin
                    pre_frame_clken = 1'b0;
                    tick();
                end
                pre_frame_clken = 1'b1;
                grad_mag = 8'(img_mag[y][x]);
                grad_dir = img_dir[y][x];
                sb.push_back(model(x, y));
                tick();
            end
            pre_frame_clken = 1'b0;
            pre_frame_href  = 1'b0;
            grad_mag = '0;
            repeat (3) tick();
        end
        repeat (4) tick();
    endtask

    initial begin
        repeat (3) tick();
        rst_s = 1'b0;
        repeat (2) tick();

        $display("[TB] flat field");
        fill(0, 2'd0);  apply_stimulus(8, 6, 0, -1);
        $display("[TB] vertical ridge, dir 0 and dir 2");
        fill(1, 2'd0);  apply_stimulus(8, 6, 0, -1);
        fill(1, 2'd2);  apply_stimulus(8, 6, 0, -1);
        $display("[TB] diagonal sectors");
        fill(2, 2'd1);  apply_stimulus(5, 5, 0, -1);
        fill(2, 2'd3);  apply_stimulus(5, 5, 0, -1);
        $display("[TB] ridge with clken gaps");
        fill(1, 2'd0);  apply_stimulus(8, 6, 30, -1);
        $display("[TB] mid-frame reset then fresh frame");
        fill(3, 2'd0);  apply_stimulus(8, 6, 0, 3);
        fill(3, 2'd0);  apply_stimulus(10, 6, 20, -1);
        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            fill(3, 2'd0);
            apply_stimulus(6 + f, 5 + (f % 3), 25, -1);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending outputs expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
